// File: rtl/squarewave_pkg.sv
// rtl/squarewave_pkg.sv - shared state encoding, unit widths and counter sizing
package squarewave_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int UNIT_W   = 4;
  localparam int UNIT_MAX = 15;

  // Wide enough to hold 16 units worth of cycles, the saturation point.
  function automatic int cnt_width(input int tick_cycles);
    return $clog2(16 * tick_cycles + 1);
  endfunction

endpackage

// File: rtl/squarewave_run_counter.sv
// rtl/squarewave_run_counter.sv - saturating run-length counter with rounding quantiser
module squarewave_run_counter
  import squarewave_pkg::*;
#(
  parameter int TICK_CYCLES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              restart,
  output logic [UNIT_W-1:0] units,
  output logic              sat
);

  localparam int CNT_W   = cnt_width(TICK_CYCLES);
  localparam int SUM_W   = CNT_W + 1;
  localparam int CNT_MAX = 16 * TICK_CYCLES;

  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] quo;

  // restart loads 1 because the edge that sees the new level is itself the first sample of the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CNT_W'(1);
    end else if (!sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sat = (cnt == CNT_W'(CNT_MAX));

  always_comb begin
    sum   = {1'b0, cnt} + SUM_W'(TICK_CYCLES / 2);
    quo   = sum / SUM_W'(TICK_CYCLES);
    units = (quo > SUM_W'(UNIT_MAX)) ? UNIT_W'(UNIT_MAX) : quo[UNIT_W-1:0];
  end

endmodule

// File: rtl/squarewave_analyzer.sv
// rtl/squarewave_analyzer.sv - measures high/low durations of a square wave in time units
module squarewave_analyzer
  import squarewave_pkg::*;
#(
  parameter int TICK_CYCLES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w,
  output logic [UNIT_W-1:0] m,
  output logic [UNIT_W-1:0] n,
  output logic              valid,
  output logic              locked,
  output logic              timeout
);

  state_t            state, state_next;
  logic              w_d;
  logic              rise, fall;
  logic              cnt_clear, cnt_restart;
  logic [UNIT_W-1:0] units;
  logic              sat;
  logic [UNIT_W-1:0] hi_tmp;
  logic              latch_hi, report, expire;

  // w_d resets high so a wave already high at reset release is not taken as a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_d <= 1'b1;
    end else begin
      w_d <= w;
    end
  end

  assign rise = w & ~w_d;
  assign fall = ~w & w_d;

  assign cnt_clear   = (state == ST_SYNC) && !rise;
  assign cnt_restart = rise || (fall && (state != ST_SYNC));

  squarewave_run_counter #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_run_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .restart(cnt_restart),
    .units  (units),
    .sat    (sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // A level change takes priority over saturation at the same edge.
  always_comb begin
    state_next = state;
    case (state)
      ST_SYNC: if (rise) state_next = ST_HIGH;
      ST_HIGH: begin
        if (fall)     state_next = ST_LOW;
        else if (sat) state_next = ST_SYNC;
      end
      ST_LOW: begin
        if (rise)     state_next = ST_HIGH;
        else if (sat) state_next = ST_SYNC;
      end
      default: state_next = ST_SYNC;
    endcase
  end

  always_comb begin
    latch_hi = 1'b0;
    report   = 1'b0;
    expire   = 1'b0;
    case (state)
      ST_HIGH: begin
        latch_hi = fall;
        expire   = !fall && sat;
      end
      ST_LOW: begin
        report = rise;
        expire = !rise && sat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_tmp  <= '0;
      m       <= '0;
      n       <= '0;
      valid   <= 1'b0;
      locked  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid  <= report;
      locked <= (state_next != ST_SYNC);
      if (latch_hi) hi_tmp <= units;
      if (report) begin
        m       <= hi_tmp;
        n       <= units;
        timeout <= 1'b0;
      end else if (expire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
